// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU and host), the arbiter and
// the single shared memory port.
interface mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  // Operating mode of the CPU: 00 idle, 01 IN, 10 CHECK, 11 RUN
  logic [1:0]    mode;

  // CPU requester
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  // Host loader/checker requester
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_ack;
  logic [DW-1:0] host_rdata;

  // Shared memory port
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbitration status
  logic [1:0]    grant;
  logic          busy;

  // Environment side: requesters and memory
  modport master (
    output mode,
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata,
    input  grant, busy
  );

  // Arbiter side
  modport slave (
    input  mode,
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata,
    output grant, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: a CPU and a host share one memory port.
// Each access runs IDLE -> ACCESS (WAIT cycles) -> ACK (1 cycle) -> IDLE.
// In RUN mode the CPU has priority but the host is guaranteed a slot after
// FAIR back-to-back CPU grants; in IN/CHECK modes only the host is served.
module mem_arbiter #(
  parameter int AW   = 16,
  parameter int DW   = 8,
  parameter int WAIT = 2,   // access cycles, 1..15
  parameter int FAIR = 4    // max consecutive CPU grants while host waits
) (
  input logic         clk,
  input logic         reset,
  mem_arbiter_if.slave bus
);

  localparam int FW = (FAIR < 1) ? 1 : $clog2(FAIR + 1);

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_CPU  = 2'b01;
  localparam logic [1:0] GRANT_HOST = 2'b10;
  localparam logic [1:0] MODE_IDLE  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    ACK    = 2'b10
  } state_t;

  state_t        state_reg;
  logic [1:0]    grant_reg;
  logic          we_reg;
  logic [AW-1:0] addr_reg;
  logic [DW-1:0] wdata_reg;
  logic [3:0]    wait_cnt_reg;
  logic [FW-1:0] fair_cnt_reg;
  logic [DW-1:0] cpu_rdata_reg;
  logic [DW-1:0] host_rdata_reg;
  logic          cpu_ack_reg;
  logic          host_ack_reg;
  logic          mem_read_reg;
  logic          mem_write_reg;

  logic cpu_win;
  logic host_win;
  logic host_starved;

  // Decide which requester would win if arbitration happened this cycle
  always_comb begin
    host_starved = bus.host_req && (fair_cnt_reg >= FW'(FAIR));
    cpu_win      = (bus.mode == MODE_RUN) && bus.cpu_req && !host_starved;
    host_win     = !cpu_win && bus.host_req && (bus.mode != MODE_IDLE);
  end

  // Arbitration FSM with registered memory strobes, acks and read data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      grant_reg      <= GRANT_NONE;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wait_cnt_reg   <= '0;
      fair_cnt_reg   <= '0;
      cpu_rdata_reg  <= '0;
      host_rdata_reg <= '0;
      cpu_ack_reg    <= 1'b0;
      host_ack_reg   <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          // A host that is not waiting resets the starvation count
          if (!bus.host_req) begin
            fair_cnt_reg <= '0;
          end
          if (cpu_win) begin
            state_reg     <= ACCESS;
            grant_reg     <= GRANT_CPU;
            we_reg        <= bus.cpu_we;
            addr_reg      <= bus.cpu_addr;
            wdata_reg     <= bus.cpu_wdata;
            mem_read_reg  <= ~bus.cpu_we;
            mem_write_reg <= bus.cpu_we;
            wait_cnt_reg  <= 4'(WAIT - 1);
            fair_cnt_reg  <= bus.host_req ? fair_cnt_reg + FW'(1) : '0;
          end else if (host_win) begin
            state_reg     <= ACCESS;
            grant_reg     <= GRANT_HOST;
            we_reg        <= bus.host_we;
            addr_reg      <= bus.host_addr;
            wdata_reg     <= bus.host_wdata;
            mem_read_reg  <= ~bus.host_we;
            mem_write_reg <= bus.host_we;
            wait_cnt_reg  <= 4'(WAIT - 1);
            fair_cnt_reg  <= '0;
          end else begin
            grant_reg <= GRANT_NONE;
          end
        end

        ACCESS: begin
          if (wait_cnt_reg == 4'd0) begin
            // Last access cycle: sample read data and raise the owner's ack
            state_reg     <= ACK;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            if (grant_reg == GRANT_CPU) begin
              cpu_ack_reg <= 1'b1;
              if (!we_reg) begin
                cpu_rdata_reg <= bus.mem_rdata;
              end
            end else begin
              host_ack_reg <= 1'b1;
              if (!we_reg) begin
                host_rdata_reg <= bus.mem_rdata;
              end
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
        end

        ACK: begin
          state_reg    <= IDLE;
          grant_reg    <= GRANT_NONE;
          cpu_ack_reg  <= 1'b0;
          host_ack_reg <= 1'b0;
        end

        default: begin
          state_reg     <= IDLE;
          grant_reg     <= GRANT_NONE;
          cpu_ack_reg   <= 1'b0;
          host_ack_reg  <= 1'b0;
          mem_read_reg  <= 1'b0;
          mem_write_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant      = grant_reg;
  assign bus.busy       = (state_reg != IDLE);
  assign bus.mem_read   = mem_read_reg;
  assign bus.mem_write  = mem_write_reg;
  assign bus.mem_addr   = addr_reg;
  assign bus.mem_wdata  = wdata_reg;
  assign bus.cpu_ack    = cpu_ack_reg;
  assign bus.cpu_rdata  = cpu_rdata_reg;
  assign bus.host_ack   = host_ack_reg;
  assign bus.host_rdata = host_rdata_reg;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 16, address width.
REQ-002 SHALL have parameter DW, default 8, data width.
REQ-003 SHALL have parameter WAIT, default 2, memory access cycles; legal range 1..15.
REQ-004 SHALL have parameter FAIR, default 4, maximum consecutive CPU grants while a host request is pending.
REQ-005 clk  in  1  clock; all state updates on the rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-low.
REQ-007 mode  in  2  CPU state: 00 idle, 01 IN, 10 CHECK, 11 RUN.
REQ-008 cpu_req, cpu_we  in  1 each  CPU access request; write when 1.
REQ-009 cpu_addr  in  AW; cpu_wdata  in  DW  CPU address and write data.
REQ-010 cpu_ack  out  1  one-cycle completion pulse; cpu_rdata  out  DW  read data.
REQ-011 host_req, host_we  in  1 each; host_addr  in  AW; host_wdata  in  DW  host loader/checker request.
REQ-012 host_ack  out  1; host_rdata  out  DW  host completion and read data.
REQ-013 mem_read, mem_write  out  1 each; mem_addr  out  AW; mem_wdata  out  DW; mem_rdata  in  DW  single shared memory port.
REQ-014 grant  out  2  current owner: 00 none, 01 CPU, 10 host; busy  out  1  high when not IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> ACK -> IDLE with no other states.
REQ-016 IDLE arbitration: mode 11 -> CPU wins over host; mode 01/10 -> host only, cpu_req ignored and left pending; mode 00 -> no grant.
REQ-017 Fairness: in mode 11, after FAIR consecutive CPU grants with host_req high at each of those arbitrations, the next arbitration SHALL grant the host if host_req is high; the counter SHALL clear on any host grant or whenever host_req is low at arbitration.
REQ-018 On grant, the owner's we/addr/wdata SHALL be latched; mem_* SHALL drive latched values, ignoring later requester input changes.
REQ-019 ACCESS SHALL last exactly WAIT cycles with mem_read=~we or mem_write=we held high throughout; both strobes SHALL be low in all other states.
REQ-020 On the last ACCESS cycle a read SHALL capture mem_rdata into the owner's rdata register; rdata SHALL hold until the next read by that owner.
REQ-021 ACK SHALL last one cycle, pulse the owner's ack, then return to IDLE; grant SHALL remain valid through ACK and return to 00 in IDLE.
REQ-022 Latency: ack high WAIT+1 cycles after the edge that leaves IDLE; back-to-back throughput of one access per WAIT+2 cycles.
REQ-023 Requesters hold req until they see ack; a req still high in IDLE after ACK is a new request.
REQ-024 A mode change during ACCESS or ACK SHALL NOT abort the access; the new mode applies at the next arbitration.
REQ-025 cpu_ack and host_ack SHALL never be high in the same cycle.

Reset
REQ-026 reset low SHALL immediately force IDLE, grant=00, busy=0, mem_read=mem_write=0, both acks=0, rdata registers=0, fairness counter=0, aborting any access in progress.
REQ-027 After reset release, the first arbitration SHALL occur on the first rising edge with reset high.

Verification
REQ-028 mode=11, cpu read addr 0x0010, mem holds 0x5A, WAIT=2 -> mem_read high 2 cycles, cpu_ack on cycle 3, cpu_rdata=0x5A.
REQ-029 mode=01, cpu_req and host write 0x0020<=0xC3 both high -> host granted, memory 0x0020=0xC3, cpu_ack never high while mode=01.
REQ-030 mode=11, cpu_req held continuously, host_req high -> CPU granted 4 times, 5th grant to host, then CPU resumes.
REQ-031 Reset pulled low in the middle of ACCESS -> mem_read/mem_write low and grant=00 the same cycle; no ack issued; a fresh request after release completes normally.
REQ-032 mode switched 11->10 during a CPU ACCESS -> CPU access completes with cpu_ack; subsequent pending cpu_req not granted until mode=11.
REQ-033 cpu_addr/cpu_wdata changed during ACCESS -> mem_addr/mem_wdata remain the latched grant-time values.
